// File: rtl/mips_debug_pkg.sv
// rtl/mips_debug_pkg.sv - shared types and constants for the MIPS register-dump engine
//
// Purpose: dump FSM state encoding and stream tag constants used by
//          regfile_dump_streamer and anything that decodes its output tags.
// Ports:   none (package).
package mips_debug_pkg;

  // Tag field width: one bit wider than a register index so the PC word
  // can be told apart from $0..$31.
  localparam int TAG_W = 6;

  // Tag carried by the program-counter word that opens every dump.
  localparam logic [TAG_W-1:0] TAG_PC = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EMIT_PC  = 3'd1,
    ST_READ     = 3'd2,
    ST_EMIT_REG = 3'd3,
    ST_FINISH   = 3'd4
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_streamer.sv
// rtl/regfile_dump_streamer.sv - streams a PC snapshot plus $0..$31 on a valid/ready port
//
// Purpose: debug readout engine for the single-cycle MIPS core. A start pulse
//          in IDLE snapshots the PC, then the register file is walked through
//          a dedicated read port, one word per READ/EMIT_REG pair.
// Ports:
//   clk        in   core clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle dump request (honoured in IDLE only)
//   pc_in      in   current program counter, captured at start
//   rf_raddr   out  register-file debug read address
//   rf_rdata   in   register-file debug read data (combinational from rf_raddr)
//   out_valid  out  stream word valid
//   out_ready  in   sink accepts word
//   out_data   out  stream word
//   out_tag    out  word identity: 32 = PC, 0..31 = register number
//   busy       out  dump in progress
//   done       out  one-cycle pulse after the last word is accepted
module regfile_dump_streamer
  import mips_debug_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pc_in,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       r_state;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [TAG_W-1:0]  r_tag;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_last;

  // out_ready only matters while a word is actually offered.
  assign w_accept = r_valid & out_ready;
  assign w_last   = (r_index == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_index <= '0;
      r_raddr <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_data  <= pc_in;
            r_tag   <= TAG_PC;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_EMIT_PC;
          end
        end

        ST_EMIT_PC: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_index <= '0;
            r_raddr <= '0;
            r_state <= ST_READ;
          end
        end

        // rf_raddr has been stable since the previous edge, so rf_rdata is
        // the live value of the addressed register this cycle.
        ST_READ: begin
          r_data  <= rf_rdata;
          r_tag   <= TAG_W'(r_index);
          r_valid <= 1'b1;
          r_state <= ST_EMIT_REG;
        end

        ST_EMIT_REG: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            if (w_last) begin
              // busy drops and done rises together, so done is seen in
              // the FINISH cycle; the index is left parked at the top.
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_index <= r_index + 1'b1;
              r_raddr <= r_index + 1'b1;
              r_state <= ST_READ;
            end
          end
        end

        // start is deliberately not looked at here: a new dump must be
        // requested from IDLE.
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rf_raddr  = r_raddr;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_tag   = r_tag;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// tb/tb_regfile_dump_streamer.sv - self-checking bench for regfile_dump_streamer
module tb_regfile_dump_streamer;
  import mips_debug_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pc_in;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_tag;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;

  regfile_dump_streamer #(
    .DATA_W   (32),
    .NUM_REGS (32),
    .ADDR_W   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pc_in     (pc_in),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
  } word_t;

  typedef struct {
    logic [31:0] pc;
    int          rm;          // 0 ready high, 1 random, 2 scripted stalls
    bit          drift;
    int          busy_word;   // word index at which a stray start is sent, -1 none
    bit          fin_start;
    int          exp_done;
  } vec_t;

  word_t       exp_q[$];
  int          cmp_cnt = 0;
  int          mis_cnt = 0;
  int          rmode = 0;
  int          word_cnt = 0;
  int          done_cnt = 0;
  int          stall_pc = 0;
  int          stall_ra = 0;
  bit          saw_done = 0;
  bit          saw_busy = 0;
  bit          saw_valid = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic [5:0]  prev_tag = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Negedge observer: scoreboard on accepted words plus stream-hold rules.
  task automatic monitor();
    word_t e;
    saw_done  = 0;
    saw_busy  = 0;
    saw_valid = 0;
    if (!rst_n) begin
      prev_stall = 0;
      return;
    end
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
      chk("hold_tag", out_tag, prev_tag);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("word_tag", out_tag, e.tag);
        chk("word_data", out_data, e.data);
      end
      word_cnt++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_tag   = out_tag;
    saw_done   = done;
    saw_busy   = busy;
    saw_valid  = out_valid;
    if (done) done_cnt++;
  endtask

  // One clock: drive inputs just after posedge, observe at negedge.
  task automatic step(input logic st);
    start = st;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && out_tag == 6'd32 && stall_pc < 5) begin
          out_ready = 1'b0;
          stall_pc++;
        end else if (out_valid && out_tag == 6'd31 && stall_ra < 3) begin
          out_ready = 1'b0;
          stall_ra++;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_rf();
    for (int i = 0; i < 32; i++) rf[i] = $urandom();
  endtask

  // Reference: a dump is the PC at start followed by the register file in order.
  task automatic run_dump(input logic [31:0] pc, input int rm, input bit drift,
                          input int busy_word, input bit fin_start,
                          output int done_cyc, output int busy_cyc,
                          output int first_valid, output int words);
    int   w0;
    int   t;
    bit   issued;
    logic st;
    rmode    = rm;
    stall_pc = 0;
    stall_ra = 0;
    pc_in    = pc;
    exp_q.push_back('{TAG_PC, pc});
    for (int i = 0; i < 32; i++) exp_q.push_back('{6'(i), rf[i]});
    w0          = word_cnt;
    done_cyc    = -1;
    busy_cyc    = 0;
    first_valid = -1;
    issued      = 0;
    t           = 0;
    step(1'b1);
    while (done_cyc < 0 && t < 3000) begin
      t++;
      if (drift && t == 1) pc_in = 32'hDEADBEEF;
      st = 1'b0;
      if (busy_word >= 0 && !issued && (word_cnt - w0) == busy_word) begin
        st     = 1'b1;
        issued = 1;
      end
      if (fin_start && t == 66) st = 1'b1;
      step(st);
      if (saw_busy) busy_cyc++;
      if (saw_valid && first_valid < 0) first_valid = t;
      if (saw_done) done_cyc = t;
    end
    if (done_cyc < 0) chk("dump_timeout", 0, 1);
    words = word_cnt - w0;
  endtask

  vec_t vecs[6];

  initial begin : guard
    #5ms;
    $display("FAIL global_timeout: got no finish, expected finish (compared %0d)", cmp_cnt);
    $fatal(1, "timeout");
  end

  initial begin : main
    int  dc, bc, fv, wc, d0;
    bit  found;

    vecs[0] = '{32'h0000_0054, 0, 0, -1, 0, 66};   // basic dump
    vecs[1] = '{32'h0000_0054, 0, 1, -1, 0, 66};   // PC drift after start
    vecs[2] = '{32'h1000_0000, 0, 0, 10, 0, 66};   // start while busy
    vecs[3] = '{32'hFFFF_FFFC, 0, 0, -1, 1, 66};   // start in done cycle
    vecs[4] = '{32'h0000_0400, 2, 0, -1, 0, 74};   // 5 + 3 stall cycles
    vecs[5] = '{32'h8000_0001, 0, 0, -1, 0, 66};

    rst_n     = 1'b0;
    start     = 1'b0;
    pc_in     = '0;
    out_ready = 1'b0;
    rand_rf();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_raddr", rf_raddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);

    for (int i = 0; i < 6; i++) begin
      rand_rf();
      if (i == 0) begin
        rf[8]  = 32'h11;
        rf[9]  = 32'h7;
        rf[10] = 32'h3;
      end
      d0 = done_cnt;
      run_dump(vecs[i].pc, vecs[i].rm, vecs[i].drift, vecs[i].busy_word,
               vecs[i].fin_start, dc, bc, fv, wc);
      chk("done_cycle", dc, vecs[i].exp_done);
      chk("busy_cycles", bc, vecs[i].exp_done - 1);
      chk("first_valid", fv, 1);
      chk("word_count", wc, 33);
      rmode = 0;
      step(1'b0);
      step(1'b0);
      step(1'b0);
      chk("done_pulses", done_cnt - d0, 1);
      chk("idle_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("queue_drained", exp_q.size(), 0);
    end

    // Reset asserted while $s3 is on the stream.
    rand_rf();
    rmode = 0;
    pc_in = 32'h0000_0054;
    exp_q.push_back('{TAG_PC, pc_in});
    for (int i = 0; i < 32; i++) exp_q.push_back('{6'(i), rf[i]});
    step(1'b1);
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      step(1'b0);
      if (out_valid && out_tag == 6'd19) found = 1;
    end
    chk("reached_s3", found, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_tag", out_tag, 0);
    chk("abort_raddr", rf_raddr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    d0 = done_cnt;
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("abort_no_done", done_cnt - d0, 0);
    rand_rf();
    run_dump(32'h0000_0054, 0, 0, -1, 0, dc, bc, fv, wc);
    chk("post_reset_done", dc, 66);
    chk("post_reset_words", wc, 33);

    // Back-to-back dumps under random backpressure.
    d0 = done_cnt;
    for (int k = 0; k < 20; k++) begin
      rand_rf();
      run_dump($urandom(), 1, 0, -1, 0, dc, bc, fv, wc);
      chk("rand_words", wc, 33);
    end
    rmode = 0;
    step(1'b0);
    step(1'b0);
    chk("rand_done_count", done_cnt - d0, 20);
    chk("rand_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_dump_streamer.md
Name: regfile_dump_streamer

Overview:
Debug readout engine for the single-cycle MIPS core. On a start pulse it snapshots the PC, then walks the 32-entry register file through a dedicated read port. It emits PC followed by $0..$31 as 33 words on a valid/ready stream, and feeds the host-side logger or UART bridge. This puts the end-of-program register dump in hardware instead of in bench code.

Parameters:
DATA_W, 32, width of PC, register words and out_data
NUM_REGS, 32, number of register-file entries walked (power of two, ≤ 32)
ADDR_W, 5, register-file address width (log2 NUM_REGS)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a dump
pc_in  in  DATA_W  current program-counter value
rf_raddr  out  ADDR_W  register-file debug read address
rf_rdata  in  DATA_W  register-file debug read data (combinational, same cycle as rf_raddr)
out_valid  out  1  stream word valid
out_ready  in  1  sink accepts word
out_data  out  DATA_W  stream word
out_tag  out  6  word identity: 6'd32 = PC, 0..31 = register number
busy  out  1  dump in progress
done  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid=0, out_data=0, out_tag=0, rf_raddr=0, busy=0, done=0; index counter=0.
- States: IDLE, EMIT_PC, READ, EMIT_REG, FINISH.
- IDLE: start=1 → capture pc_in into out_data; out_tag=32; out_valid=1; busy=1; go to EMIT_PC. start=0 → stay.
- EMIT_PC: hold out_data/out_tag stable while out_valid & !out_ready. When out_valid & out_ready → out_valid=0; index=0; rf_raddr=0; go to READ.
- READ (one cycle): register rf_rdata into out_data; out_tag=index; out_valid=1 → EMIT_REG. This gives one bubble cycle per word; rf_raddr is stable during READ.
- EMIT_REG: hold until handshake. On accept:
  - index==NUM_REGS-1 → out_valid=0, go to FINISH.
  - otherwise → index+1, rf_raddr=index+1, out_valid=0, go to READ.
- FINISH: done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: start to first out_valid = 1 cycle. With out_ready tied high, a dump is 1 + 2×NUM_REGS + 1 cycles from start to done (66 for 32 registers).
- Handshake rules:
  - out_valid is never deasserted without acceptance.
  - out_data/out_tag never change while out_valid & !out_ready.
  - out_ready is ignored while out_valid=0.
- start while busy: ignored, no restart, no effect on the stream.
- start in the same cycle as the FINISH done pulse: ignored. A new dump needs start in IDLE.
- PC snapshot is taken at start only; later pc_in changes do not affect the dump.
- Register values are sampled in each READ cycle, not at start. The core is expected to be halted; this is a live read.
- $0 is streamed as read from rf_rdata, no forced zero.
- Index wraps never; the counter stops at NUM_REGS-1.
- Reset mid-dump: immediate abort to reset values, no done pulse.

Decomposition:
- Shared package (mips_debug_pkg): state encoding constants, TAG_PC=6'd32, TAG_W=6.
- No sub-module; a single FSM plus counter and output register.

Test Plan:
- Basic dump: PC=0x00000054, $t0..$t2 = 0x11/0x7/0x3, ready tied high, pulse start → 33 words: tag 32 data 0x54, then tags 0..31 with matching RF contents; done pulses at cycle 66; busy high cycles 1..65.
- Backpressure: ready low 5 cycles on the PC word and 3 cycles on $ra → out_data/out_tag held stable throughout; no word lost or duplicated; total count 33.
- Start while busy: second start pulse at word 10 → stream unchanged, exactly one done pulse.
- PC drift: pc_in changes to 0xDEADBEEF one cycle after start → PC word still 0x00000054.
- Reset mid-dump: rst_n low at $s3 → all outputs 0 within the same cycle, no done. After release, a new start yields a full 33-word dump.
- Random ready (50%) over 20 back-to-back dumps → every dump delivers tags 32,0..31 in order with correct data; done count = 20.
